extend_pipe: RTL
================

Name: extend_pipe

Overview:
- Parametrised, registered successor to the combinational immediate extender in the MIPS datapath.
- Converts an IN_W-bit immediate to OUT_W bits in one of four modes: zero, sign, upper (LUI) or branch offset (sign extend then shift left 2).
- Valid/ready handshakes on both sides with a 2-entry skid buffer, so it sits between decode and execute without combinational ready paths.
- Carries a side-band tag so results can be matched to instructions.

Parameters:
- IN_W, 16, immediate input width; must satisfy IN_W >= 2.
- OUT_W, 32, extended output width; must satisfy OUT_W >= IN_W + 2.
- TAG_W, 4, side-band tag width; passed through unchanged.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input transaction valid.
- in_ready  out  1  block can accept input.
- in_imm  in  IN_W  immediate field.
- in_mode  in  2  00 zero, 01 sign, 10 upper, 11 branch.
- in_tag  in  TAG_W  side-band tag.
- out_valid  out  1  output holds a result.
- out_ready  in  1  downstream accepts the result.
- out_data  out  OUT_W  extended value.
- out_tag  out  TAG_W  tag of the result on out_data.
- count_o  out  16  accepted-transaction count; present only with EXT_CNT_EN.

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset values: out_valid=0, in_ready=1, out_data=0, out_tag=0, skid buffer empty, count_o=0.
- Reset asserted mid-operation discards all held entries immediately.
- Transfer rules: an input transfer happens on a rising edge with in_valid & in_ready; an output transfer happens with out_valid & out_ready.
- Modes (combinational core, then registered):
  - zero: upper OUT_W-IN_W bits are 0.
  - sign: replicate in_imm[IN_W-1].
  - upper: in_imm placed in bits [OUT_W-1 : OUT_W-IN_W], low bits 0.
  - branch: sign-extend to OUT_W, then shift left 2; the 2 MSBs shifted out are discarded, and the OUT_W constraint guarantees no significant bits are lost.
- Latency: 1 cycle. An input accepted at edge N is visible on out_data/out_valid after edge N when the output register is free.
- States (by occupancy):
  - EMPTY: out_valid=0, in_ready=1. Input transfer -> ONE.
  - ONE: out_valid=1, in_ready=1.
    - Input and output transfer in the same cycle -> stay ONE; the output register loads the new result.
    - Input only -> FULL; the new result goes to the skid register.
    - Output only -> EMPTY.
  - FULL: out_valid=1, in_ready=0.
    - Output transfer -> ONE; the skid entry moves to the output register in the same edge.
- in_ready is a registered output: it depends only on state, never combinationally on out_ready.
- Ordering: results leave strictly in acceptance order. out_data and out_tag stay stable while out_valid=1 and out_ready=0.
- Protocol violation: in_valid while in_ready=0 is ignored and must not corrupt state.

Optional Feature:
- Macro: EXT_CNT_EN.
- With EXT_CNT_EN defined: port count_o exists. It is a 16-bit register that increments on every input transfer, wraps from 0xFFFF to 0x0000, and resets to 0.
- Without it: the port and the counter are absent; all other behaviour is identical.

Decomposition:
- Package ext_pkg:
  - 2-bit mode typedef ext_mode_t.
  - Constants EXT_ZERO=2'b00, EXT_SIGN=2'b01, EXT_UPPER=2'b10, EXT_BRANCH=2'b11.
- Sub-module ext_core: purely combinational mode/width conversion, parametrised by IN_W and OUT_W. extend_pipe instantiates it once, on the input side, so both registers store already-extended values.

Test Plan:
- Defaults, out_ready=1. Inputs 0xFFF0 / 0x0FF0 in each mode, expected outputs:
  - 0xFFF0: zero 0x0000FFF0, sign 0xFFFFFFF0, upper 0xFFF00000, branch 0xFFFFFFC0.
  - 0x0FF0: zero 0x00000FF0, sign 0x00000FF0, upper 0x0FF00000, branch 0x00003FC0.
  - All results appear 1 cycle after acceptance with out_tag matching in_tag.
- Backpressure: out_ready=0, send tags 1, 2, 3 back-to-back.
  - Tags 1 and 2 are accepted; in_ready=0 after the second acceptance; tag 3 is held by the source.
  - Then out_ready=1: outputs appear in order 1, 2, 3 with no loss or duplication.
- Simultaneous transfer in state ONE: in_valid=1 and out_ready=1 for 10 cycles -> one result per cycle, in_ready stays 1, state remains ONE.
- Reset mid-operation: fill to FULL, pulse rst_n low between clock edges -> out_valid=0 and in_ready=1 immediately, before the next edge; no stale data after release.
- Parametrisation: IN_W=8, OUT_W=16, sign mode, imm 0x80 -> 0xFF80; branch mode, imm 0x7F -> 0x01FC.
- With EXT_CNT_EN: preload via 65535 transfers, one more transfer -> count_o wraps to 0x0000; without the macro the build compiles with no count_o port.

Source files
------------

// File: rtl/ext_pkg.sv
// rtl/ext_pkg.sv - shared mode encoding for the immediate extender
// Purpose: defines the 2-bit extension mode type used by ext_core and
// extend_pipe.
// Ports: none (package).
package ext_pkg;

  typedef enum logic [1:0] {
    EXT_ZERO   = 2'b00,
    EXT_SIGN   = 2'b01,
    EXT_UPPER  = 2'b10,
    EXT_BRANCH = 2'b11
  } ext_mode_t;

endpackage

// File: rtl/ext_core.sv
// rtl/ext_core.sv - combinational immediate width/mode conversion
// Purpose: widens an IN_W-bit immediate to OUT_W bits as zero, sign,
// upper (LUI-style) or branch offset (sign extend, then times four).
// Ports:
//   imm  in  IN_W   immediate field
//   mode in  2      ext_mode_t selector
//   ext  out OUT_W  extended value
module ext_core
  import ext_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic [IN_W-1:0]  imm,
  input  ext_mode_t        mode,
  output logic [OUT_W-1:0] ext
);

  logic [OUT_W-1:0] sext;

  always_comb begin
    sext = {{(OUT_W-IN_W){imm[IN_W-1]}}, imm};
    ext  = '0;
    case (mode)
      EXT_ZERO:   ext = {{(OUT_W-IN_W){1'b0}}, imm};
      EXT_SIGN:   ext = sext;
      EXT_UPPER:  ext = {imm, {(OUT_W-IN_W){1'b0}}};
      // OUT_W >= IN_W + 2 leaves two copies of the sign bit on top, so the
      // two bits pushed out here carry no information.
      EXT_BRANCH: ext = sext << 2;
      default:    ext = '0;
    endcase
  end

endmodule

// File: rtl/extend_pipe.sv
// rtl/extend_pipe.sv - registered immediate extender with 2-entry skid buffer
// Purpose: accepts an immediate plus tag on a valid/ready input, extends it
// through ext_core, and presents it one cycle later on a valid/ready output.
// A second (skid) register absorbs one extra result so in_ready can be a
// pure flop output with no combinational path from out_ready.
// Optional: define EXT_CNT_EN to add the 16-bit accepted-transaction counter
// on count_o.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     input handshake
//   in_imm, in_mode       immediate and 2-bit mode
//   in_tag                side-band tag, passed through
//   out_valid/out_ready   output handshake
//   out_data, out_tag     extended value and its tag
//   count_o               accepted-transaction count (EXT_CNT_EN only)
module extend_pipe
  import ext_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_imm,
  input  logic [1:0]       in_mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [TAG_W-1:0] out_tag
`ifdef EXT_CNT_EN
  ,
  output logic [15:0]      count_o
`endif
);

  // Occupancy: how many results are held (output register, then skid).
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  logic [1:0]       state_q,     state_d;
  logic             out_valid_q, out_valid_d;
  logic             in_ready_q,  in_ready_d;
  logic [OUT_W-1:0] out_data_q,  out_data_d;
  logic [TAG_W-1:0] out_tag_q,   out_tag_d;
  logic [OUT_W-1:0] skid_data_q, skid_data_d;
  logic [TAG_W-1:0] skid_tag_q,  skid_tag_d;
  logic [OUT_W-1:0] core_data;
  logic             in_fire;
  logic             out_fire;

  ext_core #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_core (
    .imm  (in_imm),
    .mode (ext_mode_t'(in_mode)),
    .ext  (core_data)
  );

  assign in_fire  = in_valid & in_ready_q;
  assign out_fire = out_valid_q & out_ready;

  always_comb begin
    state_d     = state_q;
    out_data_d  = out_data_q;
    out_tag_d   = out_tag_q;
    skid_data_d = skid_data_q;
    skid_tag_d  = skid_tag_q;
    case (state_q)
      ST_EMPTY: begin
        if (in_fire) begin
          out_data_d = core_data;
          out_tag_d  = in_tag;
          state_d    = ST_ONE;
        end
      end
      ST_ONE: begin
        if (in_fire && out_fire) begin
          out_data_d = core_data;
          out_tag_d  = in_tag;
        end else if (in_fire) begin
          skid_data_d = core_data;
          skid_tag_d  = in_tag;
          state_d     = ST_FULL;
        end else if (out_fire) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        // in_ready is low here, so only the output side can move.
        if (out_fire) begin
          out_data_d = skid_data_q;
          out_tag_d  = skid_tag_q;
          state_d    = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    // Both handshake outputs are decoded from the next state and registered.
    out_valid_d = (state_d != ST_EMPTY);
    in_ready_d  = (state_d != ST_FULL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_EMPTY;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      out_data_q  <= '0;
      out_tag_q   <= '0;
      skid_data_q <= '0;
      skid_tag_q  <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      out_data_q  <= out_data_d;
      out_tag_q   <= out_tag_d;
      skid_data_q <= skid_data_d;
      skid_tag_q  <= skid_tag_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_tag   = out_tag_q;

`ifdef EXT_CNT_EN
  logic [15:0] count_q, count_d;

  // Free-running wrap from 0xFFFF to 0x0000.
  always_comb count_d = in_fire ? count_q + 16'd1 : count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= 16'd0;
    else        count_q <= count_d;
  end

  assign count_o = count_q;
`endif

endmodule
